// File: rtl/rr_select_reg.sv
// N-channel registered select stage, round-robin or fixed priority.
// Ports: clk, rst_n, mode, in_data/in_valid/in_ready, out_data/out_sel/out_valid/out_ready.
module rr_select_reg #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [SELW:0]    sum;
  logic [SELW-1:0]  idx;
  logic [SELW-1:0]  gidx;
  logic             found;
  logic             load_ok;
  logic             in_xfer;

  // Scan NCH candidates starting at the pointer (rr) or at 0 (fixed);
  // the first valid one wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (mode) begin
        sum = (SELW+1)'(k);
      end else begin
        sum = {1'b0, ptr_q} + (SELW+1)'(k);
        if (sum >= (SELW+1)'(NCH)) begin
          sum = sum - (SELW+1)'(NCH);
        end
      end
      idx = sum[SELW-1:0];
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  assign load_ok = !valid_q || out_ready;
  // rst_n gate keeps every in_ready low while reset is held.
  assign in_xfer = load_ok && found && rst_n;

  always_comb begin
    in_ready = '0;
    if (in_xfer) begin
      in_ready[gidx] = 1'b1;
    end
  end

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (in_xfer) begin
      data_d  = in_data[gidx*WIDTH +: WIDTH];
      sel_d   = gidx;
      valid_d = 1'b1;
      if (!mode) begin
        if (gidx == SELW'(NCH-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = gidx + 1'b1;
        end
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_select_reg.sv
// Directed self-checking bench for rr_select_reg (NCH=4, WIDTH=32).
// One task per scenario; each does its own inline comparisons.
module tb_rr_select_reg;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           mode;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  rr_select_reg #(.WIDTH(W), .NCH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string nm, input logic [N-1:0] exp);
    checks++;
    if (in_ready !== exp) begin
      errors++;
      $display("FAIL %s in_ready got=%b exp=%b", nm, in_ready, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic v,
                         input logic [1:0] s, input logic [W-1:0] d);
    checks++;
    if (out_valid !== v || out_sel !== s || out_data !== d) begin
      errors++;
      $display("FAIL %s got v=%b s=%0d d=%h exp v=%b s=%0d d=%h",
               nm, out_valid, out_sel, out_data, v, s, d);
    end
  endtask

  task automatic set_std_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i * 32'h11);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode = 1'b0;
    out_ready = 1'b1;
    in_valid = '0;
    set_std_data();
    #3;
    chk_out("reset_idle", 1'b0, 2'd0, 32'h0);
    in_valid = 4'b1111;
    #1;
    chk_rdy("reset_rdy", 4'b0000);
    in_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_round_robin();
    in_valid = 4'b1111;
    #1;
    chk_rdy("rr_first", 4'b0001);
    for (int c = 0; c < 6; c++) begin
      step();
      chk_out($sformatf("rr_c%0d", c), 1'b1, 2'(c % 4),
              W'((c % 4) * 32'h11));
    end
    // pointer now at 2; async reset must clear everything without a clock
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("midreset_out", 1'b0, 2'd0, 32'h0);
    chk_rdy("midreset_rdy", 4'b0000);
    step();
    rst_n = 1'b1;
    #1;
    chk_rdy("post_reset_rdy", 4'b0001);
    step();
    chk_out("post_reset_out", 1'b1, 2'd0, 32'h0);
  endtask

  task automatic test_fixed();
    mode = 1'b1;
    in_valid = 4'b1010;
    #1;
    chk_rdy("fixed_rdy0", 4'b0010);
    for (int c = 0; c < 4; c++) begin
      step();
      chk_out($sformatf("fixed_c%0d", c), 1'b1, 2'd1, 32'h11);
      chk_rdy($sformatf("fixed_rdy_c%0d", c), 4'b0010);
    end
  endtask

  task automatic test_backpressure();
    // pointer is 1 (retained through fixed mode)
    mode = 1'b0;
    in_data[2*W +: W] = 32'hDEADBEEF;
    in_valid = 4'b0100;
    step();
    chk_out("bp_capture", 1'b1, 2'd2, 32'hDEADBEEF);
    out_ready = 1'b0;
    in_valid = 4'b1111;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk_rdy($sformatf("bp_rdy_c%0d", c), 4'b0000);
      step();
      chk_out($sformatf("bp_hold_c%0d", c), 1'b1, 2'd2, 32'hDEADBEEF);
    end
    out_ready = 1'b1;
    #1;
    chk_rdy("bp_release_rdy", 4'b1000);
    step();
    chk_out("bp_next", 1'b1, 2'd3, 32'h33);
    set_std_data();
  endtask

  task automatic test_sparse_wrap();
    // pointer is 0; take channel 2 to move it to 3
    in_valid = 4'b0100;
    step();
    chk_out("sp_setup", 1'b1, 2'd2, 32'h22);
    in_valid = 4'b0010;
    #1;
    chk_rdy("sp_rdy1", 4'b0010);
    step();
    chk_out("sp_ch1", 1'b1, 2'd1, 32'h11);
    in_valid = 4'b1000;
    #1;
    chk_rdy("sp_rdy3", 4'b1000);
    step();
    chk_out("sp_ch3", 1'b1, 2'd3, 32'h33);
    in_valid = 4'b1111;
    #1;
    chk_rdy("sp_wrapped", 4'b0001);
  endtask

  task automatic test_idle_drain();
    in_data[0 +: W] = 32'hA5A5A5A5;
    in_valid = 4'b0001;
    step();
    chk_out("drain_beat", 1'b1, 2'd0, 32'hA5A5A5A5);
    in_valid = '0;
    #1;
    chk_rdy("drain_norq", 4'b0000);
    step();
    chk_out("drain_c1", 1'b0, 2'd0, 32'hA5A5A5A5);
    step();
    chk_out("drain_c2", 1'b0, 2'd0, 32'hA5A5A5A5);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed();
    test_backpressure();
    test_sparse_wrap();
    test_idle_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_select_reg.md
Name: rr_select_reg

Overview:
Parametrised N-channel registered select stage with valid/ready handshakes on every port, replacing hard-wired 2:1/3:1 selects where sources arrive asynchronously to each other. A combinational arbiter chooses one requesting channel per cycle, in round-robin or fixed-priority mode. The winner is captured in a single output register that carries the channel index alongside the data. Used between multi-source producers (e.g. writeback/forwarding sources, memory request ports) and a single consumer in the MIPS datapath.

Parameters:
WIDTH, 32, data width per channel
NCH, 4, number of input channels (2..16)
SELW, $clog2(NCH), width of channel index (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = round-robin, 1 = fixed priority (channel 0 highest)
in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel request
in_ready  output  NCH  per-channel accept; at most one bit high per cycle
out_data  output  WIDTH  registered selected data
out_sel  output  SELW  registered index of the channel that supplied out_data
out_valid  output  1  out_data/out_sel hold a valid beat
out_ready  input  1  consumer accept

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_sel=0, rr pointer=0. in_ready=0 while reset is asserted. Reset mid-transfer drops the held beat; no partial state survives.
- Transfer on channel i: in_valid[i] && in_ready[i] at the rising edge. Transfer on output: out_valid && out_ready.
- Output register can load when out_valid==0 or out_ready==1. Call this signal load_ok.
- Grant (combinational):
  - mode=1: lowest-index valid channel.
  - mode=0: first valid channel searching upward from the pointer, wrapping NCH-1 -> 0.
- in_ready[i] = load_ok && grant[i]. No channel is ready when none is valid. in_ready may depend combinationally on out_ready, in_valid and mode.
- On an input transfer from channel g: out_data<=in_data[g], out_sel<=g, out_valid<=1.
  - In mode 0, pointer <= (g+1) mod NCH.
  - In mode 1, the pointer is unchanged.
- Output transfer with no input transfer in the same cycle: out_valid<=0. out_data and out_sel hold their last values.
- Simultaneous output and input transfer: the new beat replaces the old one. Sustained throughput is 1 beat/cycle.
- Latency: 1 cycle from an input transfer to out_valid.
- Stall rule: while out_valid && !out_ready, out_data, out_sel and out_valid stay stable, and all in_ready bits are 0.
- Sources hold in_data/in_valid until accepted. The block never drops or duplicates a beat.
- Mode change: takes effect on the next grant decision. The pointer is retained across mode changes.
- Pointer wrap: when g=NCH-1, the pointer becomes 0. The pointer only advances on input transfers, never on idle cycles.
- Fairness (mode 0): with all channels continuously valid and out_ready=1, each channel is granted exactly once per NCH consecutive transfers.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_sel and in_ready go to 0 immediately (no clock needed); first grant after release is channel 0.
- Round-robin, NCH=4, mode=0, all in_valid=4'b1111, out_ready=1, data=chan*0x11 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles; out_data 0x00,0x11,0x22,0x33.
- Fixed priority, mode=1, in_valid=4'b1010 held, out_ready=1 -> out_sel stays 1 every cycle; in_ready=4'b0010; channel 3 is starved.
- Backpressure: one beat from channel 2 (0xDEADBEEF) captured, then out_ready=0 for 5 cycles while in_valid=4'b1111 -> out_data=0xDEADBEEF and out_sel=2 stable; in_ready=0; on out_ready=1, the next accepted channel is 3.
- Sparse/wrap: pointer=3, only in_valid[1]=1 -> grant 1, pointer becomes 2; then only in_valid[3]=1 -> grant 3, pointer wraps to 0.
- Idle drain: single beat accepted, then in_valid=0 with out_ready=1 -> out_valid high for exactly 1 cycle, then 0; out_data retains its value.
